// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_adder_pkg;

  localparam int SERIAL_ADDER_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/adder_1bit.sv
// Single-bit full adder used as the datapath of the serial adder.
module adder_1bit (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);

  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one bit per clock, LSB first, through a single full adder.
// Optional signed-overflow flag enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fa_sum, fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  adder_1bit u_fa (
    .a         (a_sh_q[0]),
    .b         (b_sh_q[0]),
    .carry_in  (carry_q),
    .sum       (fa_sum),
    .carry_out (fa_cout)
  );

  // Sum bits are shifted into the top of the A register as A's bits leave the bottom.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = done_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = carry_in;
          cnt_d   = '0;
          state_d = ST_ADD;
          busy_d  = 1'b1;
        end
      end
      ST_ADD: begin
        a_sh_d  = {fa_sum, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          sum_d   = {fa_sum, a_sh_q[WIDTH-1:1]};
          cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB during the final bit.
          ovf_d   = carry_q ^ fa_cout;
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign overflow  = ovf_q;
`else
  assign overflow  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl; results checked against a scoreboard on each done pulse.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         carry_in = 1'b0;
  logic         busy, done, carry_out, overflow;
  logic [W-1:0] sum;

  int           tests_run = 0;
  int           fail_cnt = 0;
  int           cyc = 0;
  int           done_cnt = 0;
  int           last_done_cyc = 0;
  int           prev_done_cyc = 0;
  int           d0 = 0;
  logic [W-1:0] prev_sum = '0;
  exp_t         sb[$];
  exp_t         e, e1, e2;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] s;
    exp_t r;
    s = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    r.sum  = s[W-1:0];
    r.cout = s[W];
`ifdef SERIAL_ADDER_OVF_EN
    r.ovf  = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
`else
    r.ovf  = 1'b0;
`endif
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Result monitor: every done pulse must match the oldest outstanding expectation.
  initial forever begin
    exp_t got;
    @(negedge clk);
    if (done === 1'b1) begin
      done_cnt++;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        got = sb.pop_front();
        $display("[TB] done @cyc %0d: sum=0x%02h cout=%0b ovf=%0b (exp 0x%02h %0b %0b)",
                 cyc, sum, carry_out, overflow, got.sum, got.cout, got.ovf);
        check("sum", 32'(sum), 32'(got.sum));
        check("carry_out", 32'(carry_out), 32'(got.cout));
        check("overflow", 32'(overflow), 32'(got.ovf));
      end
    end
  end

  task automatic run_op(input logic [W-1:0] a_i, input logic [W-1:0] b_i, input logic c_i);
    exp_t r;
    int   busy_n;
    int   lat;
    busy_n = 0;
    lat    = 0;
    r = model(a_i, b_i, c_i);
    sb.push_back(r);
    a = a_i; b = b_i; carry_in = c_i; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); carry_in = 1'($urandom);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) check("sum_hold_while_busy", 32'(sum), 32'(prev_sum));
      if (busy) busy_n++;
      if (done) begin
        lat = i;
        break;
      end
    end
    check("busy_cycles", 32'(busy_n), 32'(W));
    check("done_latency", 32'(lat), 32'(W + 1));
    @(negedge clk);
    check("done_one_cycle", 32'({busy, done}), 32'd0);
    prev_sum = r.sum;
    @(posedge clk); #1;
  endtask

  initial begin
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(carry_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    n_rst = 1'b1;
    @(posedge clk); #1;

    run_op(8'h0F, 8'h01, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'h00, 8'h00, 1'b1);
    run_op(8'h7F, 8'h01, 1'b0);
    run_op(8'h80, 8'h80, 1'b1);
    run_op(8'hFF, 8'hFF, 1'b1);
    for (int k = 0; k < 3; k++) run_op(8'($urandom), 8'($urandom), 1'($urandom));

    // start re-pulsed during ADD and during DONE must be ignored
    e = model(8'h21, 8'h13, 1'b0);
    sb.push_back(e);
    a = 8'h21; b = 8'h13; carry_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #1;
    a = 8'h55; b = 8'hAA; carry_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("in_done_state", 32'(done), 32'd1);
    a = 8'h01; b = 8'h02; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("ignored_start_single_done", 32'(done_cnt - d0), 32'd1);
    check("ignored_start_idle", 32'(busy), 32'd0);
    prev_sum = e.sum;

    // reset in the 4th ADD cycle abandons the operation
    a = 8'h33; b = 8'h44; carry_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #1;
    check("midop_busy", 32'(busy), 32'd1);
    n_rst = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(carry_out), 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    prev_sum = '0;
    run_op(8'hC3, 8'h5A, 1'b1);
    check("reset_no_done", 32'(done_cnt - d0), 32'd1);

    // start held high: back-to-back operations every WIDTH+2 cycles
    e1 = model(8'h12, 8'h34, 1'b0);
    e2 = model(8'h80, 8'h80, 1'b0);
    sb.push_back(e1);
    sb.push_back(e2);
    d0 = done_cnt;
    a = 8'h12; b = 8'h34; carry_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 8'h80; b = 8'h80;
    repeat (10) @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("held_second_busy", 32'(busy), 32'd1);
    check("held_sum_hold", 32'(sum), 32'h46);
    for (int i = 0; i < 40; i++) begin
      if (done_cnt - d0 >= 2) break;
      @(posedge clk); #1;
    end
    check("held_done_count", 32'(done_cnt - d0), 32'd2);
    check("held_done_spacing", 32'(last_done_cyc - prev_done_cyc), 32'd10);
    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
